// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier between NREQ requesters.
// Tracks issued ops with a tag pipe and returns each product to its originator with a strobe.
module mult_rr_scheduler #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned LEVEL = 4,
    parameter int unsigned NREQ  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*SIZE-1:0]          req_a,
    input  logic [NREQ*SIZE-1:0]          req_b,
    output logic [NREQ-1:0]               req_ready,
    output logic [SIZE-1:0]               mult_a,
    output logic [SIZE-1:0]               mult_b,
    input  logic [2*SIZE-1:0]             mult_pdt,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [2*SIZE-1:0]             rsp_pdt,
    output logic [$clog2(LEVEL+2)-1:0]    inflight
);
    localparam int unsigned LAT = LEVEL + 1;
    localparam int unsigned IW  = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(LAT + 1);

    logic [IW-1:0]  ptr;
    logic           grant;
    logic [IW-1:0]  gnt_id;
    logic [IW-1:0]  idx;
    logic [LAT-1:0] tag_vld;
    logic [IW-1:0]  tag_id [LAT];
    logic           done;

    // First valid requester at or after ptr, with wrap; suppressed while in reset.
    always_comb begin
        grant  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = IW'((32'(ptr) + off) % NREQ);
            if (!grant && req_valid[idx]) begin
                grant  = 1'b1;
                gnt_id = idx;
            end
        end
        if (rst) begin
            grant = 1'b0;
        end
    end

    assign req_ready = grant ? (NREQ'(1) << gnt_id) : '0;
    assign mult_a    = grant ? req_a[32'(gnt_id)*SIZE +: SIZE] : '0;
    assign mult_b    = grant ? req_b[32'(gnt_id)*SIZE +: SIZE] : '0;
    assign done      = tag_vld[LAT-1];

    // Tag pipe mirrors the multiplier depth so the id lines up with its product.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[LAT-2:0], grant};
            tag_id[0] <= gnt_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_pdt   <= '0;
            inflight  <= '0;
        end else begin
            rsp_valid <= done ? (NREQ'(1) << tag_id[LAT-1]) : '0;
            if (done) begin
                rsp_pdt <= mult_pdt;
            end
            if (grant && !done) begin
                inflight <= inflight + CW'(1);
            end else if (!grant && done) begin
                inflight <= inflight - CW'(1);
            end
            if (grant) begin
                ptr <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed-vector bench for mult_rr_scheduler with a behavioural pipelined multiplier.
module tb_mult_rr_scheduler;
    localparam int unsigned SIZE  = 8;
    localparam int unsigned LEVEL = 4;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned LAT   = LEVEL + 1;
    localparam int unsigned IFW   = $clog2(LAT + 1);

    typedef struct {
        logic [NREQ-1:0]      valid;
        logic [NREQ*SIZE-1:0] a;
        logic [NREQ*SIZE-1:0] b;
        logic [NREQ-1:0]      ready;
        logic [SIZE-1:0]      ma;
        logic [SIZE-1:0]      mb;
        logic [NREQ-1:0]      rv;
        logic [2*SIZE-1:0]    pdt;
        logic [IFW-1:0]       inf;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic [SIZE-1:0]      mult_a;
    logic [SIZE-1:0]      mult_b;
    logic [2*SIZE-1:0]    mult_pdt;
    logic [NREQ-1:0]      rsp_valid;
    logic [2*SIZE-1:0]    rsp_pdt;
    logic [IFW-1:0]       inflight;

    logic [2*SIZE-1:0] mstage [LAT];
    int checks;
    int failures;
    vec_t tbl [$];

    mult_rr_scheduler #(.SIZE(SIZE), .LEVEL(LEVEL), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b), .mult_pdt(mult_pdt),
        .rsp_valid(rsp_valid), .rsp_pdt(rsp_pdt), .inflight(inflight)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External multiplier: input register plus LEVEL output stages, no reset.
    initial begin
        for (int k = 0; k < LAT; k++) mstage[k] = '0;
    end
    always @(posedge clk) begin
        mstage[0] <= (2*SIZE)'(mult_a) * (2*SIZE)'(mult_b);
        for (int k = 1; k < LAT; k++) mstage[k] <= mstage[k-1];
    end
    assign mult_pdt = mstage[LAT-1];

    function automatic logic [NREQ*SIZE-1:0] p4(input int x3, input int x2, input int x1, input int x0);
        return {SIZE'(x3), SIZE'(x2), SIZE'(x1), SIZE'(x0)};
    endfunction

    function automatic vec_t mk(input logic [NREQ-1:0] v, input logic [NREQ*SIZE-1:0] a,
                                input logic [NREQ*SIZE-1:0] b, input logic [NREQ-1:0] rdy,
                                input int ma, input int mb, input logic [NREQ-1:0] rv,
                                input int pdt, input int inf);
        vec_t r;
        r.valid = v;  r.a = a;  r.b = b;  r.ready = rdy;
        r.ma = SIZE'(ma);  r.mb = SIZE'(mb);  r.rv = rv;
        r.pdt = (2*SIZE)'(pdt);  r.inf = IFW'(inf);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check comb and registered outputs, then advance one edge.
    task automatic run_row(input vec_t v, input string grp, input int row);
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        #1;
        chk({grp, ".ready"},     row, 32'(req_ready), 32'(v.ready));
        chk({grp, ".mult_a"},    row, 32'(mult_a),    32'(v.ma));
        chk({grp, ".mult_b"},    row, 32'(mult_b),    32'(v.mb));
        chk({grp, ".rsp_valid"}, row, 32'(rsp_valid), 32'(v.rv));
        chk({grp, ".rsp_pdt"},   row, 32'(rsp_pdt),   32'(v.pdt));
        chk({grp, ".inflight"},  row, 32'(inflight),  32'(v.inf));
        tick();
    endtask

    initial begin
        logic [NREQ*SIZE-1:0] a1, b1, a2, b2, a3, b3, af, bf, ar, br;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;

        a1 = p4(0, 200, 0, 0);   b1 = p4(0, 100, 0, 0);
        a2 = p4(1, 0, 0, 255);   b2 = p4(1, 0, 255, 255);
        a3 = p4(255, 100, 10, 3); b3 = p4(2, 200, 20, 7);
        af = p4(12, 0, 0, 9);    bf = p4(11, 0, 0, 9);
        ar = p4(0, 6, 4, 2);     br = p4(0, 7, 5, 3);

        // Single request, LAT-cycle return
        tbl.push_back(mk(4'b0100, a1, b1, 4'b0100, 200, 100, 4'b0000, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0000, a1, b1, 4'b0000, 0, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(4'b0000, a1, b1, 4'b0000, 0, 0, 4'b0100, 20000, 0));
        tbl.push_back(mk(4'b0000, a1, b1, 4'b0000, 0, 0, 4'b0000, 20000, 0));
        // Edge operand values with idle gaps between issues
        tbl.push_back(mk(4'b0001, a2, b2, 4'b0001, 255, 255, 4'b0000, 20000, 0));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b0000, 20000, 1));
        tbl.push_back(mk(4'b0010, a2, b2, 4'b0010, 0, 255, 4'b0000, 20000, 1));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b0000, 20000, 2));
        tbl.push_back(mk(4'b1000, a2, b2, 4'b1000, 1, 1, 4'b0000, 20000, 2));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b0000, 20000, 3));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b0001, 65025, 2));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b0000, 65025, 2));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b0010, 0, 1));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b1000, 1, 0));
        tbl.push_back(mk(4'b0000, a2, b2, 4'b0000, 0, 0, 4'b0000, 1, 0));
        // All four valid every cycle: 0,1,2,3,0,... and inflight saturates at LAT
        tbl.push_back(mk(4'b1111, a3, b3, 4'b0001, 3, 7, 4'b0000, 1, 0));
        tbl.push_back(mk(4'b1111, a3, b3, 4'b0010, 10, 20, 4'b0000, 1, 1));
        tbl.push_back(mk(4'b1111, a3, b3, 4'b0100, 100, 200, 4'b0000, 1, 2));
        tbl.push_back(mk(4'b1111, a3, b3, 4'b1000, 255, 2, 4'b0000, 1, 3));
        tbl.push_back(mk(4'b1111, a3, b3, 4'b0001, 3, 7, 4'b0000, 1, 4));
        tbl.push_back(mk(4'b1111, a3, b3, 4'b0010, 10, 20, 4'b0000, 1, 5));
        tbl.push_back(mk(4'b1111, a3, b3, 4'b0100, 100, 200, 4'b0001, 21, 5));
        tbl.push_back(mk(4'b1111, a3, b3, 4'b1000, 255, 2, 4'b0010, 200, 5));
        tbl.push_back(mk(4'b0000, a3, b3, 4'b0000, 0, 0, 4'b0100, 20000, 5));
        tbl.push_back(mk(4'b0000, a3, b3, 4'b0000, 0, 0, 4'b1000, 510, 4));
        tbl.push_back(mk(4'b0000, a3, b3, 4'b0000, 0, 0, 4'b0001, 21, 3));
        tbl.push_back(mk(4'b0000, a3, b3, 4'b0000, 0, 0, 4'b0010, 200, 2));
        tbl.push_back(mk(4'b0000, a3, b3, 4'b0000, 0, 0, 4'b0100, 20000, 1));
        tbl.push_back(mk(4'b0000, a3, b3, 4'b0000, 0, 0, 4'b1000, 510, 0));
        tbl.push_back(mk(4'b0000, a3, b3, 4'b0000, 0, 0, 4'b0000, 510, 0));

        tick();
        tick();
        // Reset state, with grants suppressed even though every request is valid
        run_row(mk(4'b1111, a3, b3, 4'b0000, 0, 0, 4'b0000, 0, 0), "reset", 0);
        rst = 1'b0;

        foreach (tbl[i]) run_row(tbl[i], "tbl", i);

        // Fairness: req3 arriving at ptr=1 beats the held req0
        run_row(mk(4'b0001, af, bf, 4'b0001, 9, 9, 4'b0000, 510, 0), "fair", 0);
        run_row(mk(4'b1001, af, bf, 4'b1000, 12, 11, 4'b0000, 510, 1), "fair", 1);
        run_row(mk(4'b0001, af, bf, 4'b0001, 9, 9, 4'b0000, 510, 2), "fair", 2);
        for (int i = 3; i < 6; i++) run_row(mk(4'b0000, af, bf, 4'b0000, 0, 0, 4'b0000, 510, 3), "fair", i);
        run_row(mk(4'b0000, af, bf, 4'b0000, 0, 0, 4'b0001, 81, 2), "fair", 6);
        run_row(mk(4'b0000, af, bf, 4'b0000, 0, 0, 4'b1000, 132, 1), "fair", 7);
        run_row(mk(4'b0000, af, bf, 4'b0000, 0, 0, 4'b0001, 81, 0), "fair", 8);
        run_row(mk(4'b0000, af, bf, 4'b0000, 0, 0, 4'b0000, 81, 0), "fair", 9);

        // Reset with three ops in flight: all dropped, pointer back to 0
        run_row(mk(4'b0111, ar, br, 4'b0010, 4, 5, 4'b0000, 81, 0), "rst", 0);
        run_row(mk(4'b0111, ar, br, 4'b0100, 6, 7, 4'b0000, 81, 1), "rst", 1);
        run_row(mk(4'b0111, ar, br, 4'b0001, 2, 3, 4'b0000, 81, 2), "rst", 2);
        rst = 1'b1;
        run_row(mk(4'b0011, ar, br, 4'b0000, 0, 0, 4'b0000, 81, 3), "rst", 3);
        rst = 1'b0;
        for (int i = 4; i < 12; i++) run_row(mk(4'b0000, ar, br, 4'b0000, 0, 0, 4'b0000, 0, 0), "rst", i);
        run_row(mk(4'b0011, ar, br, 4'b0001, 2, 3, 4'b0000, 0, 0), "rst", 12);
        for (int i = 13; i < 18; i++) run_row(mk(4'b0000, ar, br, 4'b0000, 0, 0, 4'b0000, 0, 1), "rst", i);
        run_row(mk(4'b0000, ar, br, 4'b0000, 0, 0, 4'b0001, 6, 0), "rst", 18);
        run_row(mk(4'b0000, ar, br, 4'b0000, 0, 0, 4'b0000, 6, 0), "rst", 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
